mem_access_sequencer: RTL and testbench

//  Sequences data-memory loads/stores between the core's LSU stage and a single-port,

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_lane_align.sv | 51 +++++
 rtl/mem_access_sequencer.sv | 164 ++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory access sequencer.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE0 = 3'd1,
        WAIT0  = 3'd2,
        ISSUE1 = 3'd3,
        WAIT1  = 3'd4,
        DONE   = 3'd5
    } seq_state_t;

    // Reserved size, unsigned store, or unsigned word access.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        return (f3[1:0] == 2'b11) || (we && f3[2]) || (f3 == 3'b110);
    endfunction

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        logic [3:0] m;
        case (sz)
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables/data and load merge/extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [23:0] hi,
    output logic        split,
    output logic [7:0]  be8,
    output logic [63:0] wd64,
    output logic [31:0] load_data
);

    logic [2:0]  sz_bytes;
    logic [31:0] wmask;
    logic [23:0] hi_eff;
    logic [31:0] d32;
    logic        sext;

    // Size decode, store lane generation and load byte merge.
    always_comb begin
        case (funct3[1:0])
            2'b00:   begin sz_bytes = 3'd1; wmask = 32'h0000_00FF; end
            2'b01:   begin sz_bytes = 3'd2; wmask = 32'h0000_FFFF; end
            default: begin sz_bytes = 3'd4; wmask = 32'hFFFF_FFFF; end
        endcase
        split = ({1'b0, off} + sz_bytes) > 3'd4;
        be8   = {4'b0000, size_mask(funct3[1:0])} << off;
        wd64  = {32'h0000_0000, wdata & wmask} << {off, 3'b000};

        // Byte 7 of {hi,lo} can never be part of a 4-byte window, so hi is 24 bits.
        hi_eff = split ? hi : 24'h00_0000;
        case (off)
            2'd0:    d32 = lo;
            2'd1:    d32 = {hi_eff[7:0],  lo[31:8]};
            2'd2:    d32 = {hi_eff[15:0], lo[31:16]};
            2'd3:    d32 = {hi_eff[23:0], lo[31:24]};
            default: d32 = lo;
        endcase

        sext = ~funct3[2];
        case (funct3[1:0])
            2'b00:   load_data = {{24{sext & d32[7]}},  d32[7:0]};
            2'b01:   load_data = {{16{sext & d32[15]}}, d32[15:0]};
            default: load_data = d32;
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences one RV32 load/store at a time onto a fixed-latency byte-enabled BRAM,
// splitting word-crossing accesses into two word transactions.
module mem_access_sequencer
    import mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int WA_W  = ADDR_W - 2;
    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WA_W-1:0]  WORD_INC = WA_W'(1);

    seq_state_t        state_r, nxt_s;
    logic              we_r;
    logic [2:0]        funct3_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [31:0]       lo_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       lo_sel_s;
    logic              split_s;
    logic [7:0]        be8_s;
    logic [63:0]       wd64_s;
    logic [31:0]       load_data_s;
    logic              wait_last_s;

    mem_lane_align u_align (
        .funct3    (funct3_r),
        .off       (addr_r[1:0]),
        .wdata     (wdata_r),
        .lo        (lo_sel_s),
        .hi        (mem_rdata[23:0]),
        .split     (split_s),
        .be8       (be8_s),
        .wd64      (wd64_s),
        .load_data (load_data_s)
    );

    assign wait_last_s = (cnt_r == CNT_LAST);

    // Next-state and BRAM/handshake decode.
    always_comb begin
        nxt_s      = state_r;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_en     = 1'b0;
        mem_addr   = '0;
        mem_be     = 4'b0000;
        mem_wdata  = 32'h0000_0000;
        lo_sel_s   = lo_r;
        case (state_r)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    nxt_s = f3_illegal(req_we, req_funct3) ? DONE : ISSUE0;
                end else begin
                    nxt_s = IDLE;
                end
            end
            ISSUE0: begin
                mem_en   = 1'b1;
                mem_addr = addr_r[ADDR_W-1:2];
                if (we_r) begin
                    mem_be    = be8_s[3:0];
                    mem_wdata = wd64_s[31:0];
                    nxt_s     = split_s ? ISSUE1 : DONE;
                end else begin
                    nxt_s = WAIT0;
                end
            end
            WAIT0: begin
                // The merge sees the arriving low word directly so the
                // response can be registered on the capture edge.
                lo_sel_s = mem_rdata;
                if (wait_last_s) begin
                    nxt_s = split_s ? ISSUE1 : DONE;
                end else begin
                    nxt_s = WAIT0;
                end
            end
            ISSUE1: begin
                mem_en   = 1'b1;
                mem_addr = addr_r[ADDR_W-1:2] + WORD_INC;
                if (we_r) begin
                    mem_be    = be8_s[7:4];
                    mem_wdata = wd64_s[63:32];
                    nxt_s     = DONE;
                end else begin
                    nxt_s = WAIT1;
                end
            end
            WAIT1: begin
                if (wait_last_s) begin
                    nxt_s = DONE;
                end else begin
                    nxt_s = WAIT1;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                nxt_s      = IDLE;
            end
            default: nxt_s = IDLE;
        endcase
    end

    // State, request latch, latency counter, capture and response registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            we_r       <= 1'b0;
            funct3_r   <= 3'b000;
            addr_r     <= '0;
            wdata_r    <= 32'h0000_0000;
            lo_r       <= 32'h0000_0000;
            cnt_r      <= '0;
            resp_rdata <= 32'h0000_0000;
            resp_err   <= 1'b0;
        end else begin
            state_r <= nxt_s;
            if (state_r == IDLE && req_valid) begin
                we_r     <= req_we;
                funct3_r <= req_funct3;
                addr_r   <= req_addr;
                wdata_r  <= req_wdata;
            end
            if (state_r == WAIT0 || state_r == WAIT1) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= '0;
            end
            if (state_r == WAIT0 && wait_last_s) begin
                lo_r <= mem_rdata;
            end
            if ((state_r == WAIT0 || state_r == WAIT1) && nxt_s == DONE) begin
                resp_rdata <= load_data_s;
            end else begin
                resp_rdata <= 32'h0000_0000;
            end
            resp_err <= (state_r == IDLE) && (nxt_s == DONE);
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a 2-cycle-latency BRAM model.
module tb_mem_access_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_en;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    mem_access_sequencer #(.ADDR_W(32), .READ_LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // BRAM model: 256 words aliased on mem_addr[7:0], read latency 2, preload port.
    logic [31:0] bram [0:255];
    logic [31:0] rd_pipe0, rd_pipe1;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = 8'h00;
    logic [31:0] pl_data = 32'h0;

    always @(posedge clk) begin
        if (mem_en && mem_be == 4'b0000) rd_pipe0 <= bram[mem_addr[7:0]];
        else                             rd_pipe0 <= 32'hBAD0_BAD0;
        rd_pipe1 <= rd_pipe0;
        if (pl_en) bram[pl_addr] <= pl_data;
        else if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) bram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end
    assign mem_rdata = rd_pipe1;

    logic [29:0] cap_addr [0:3];
    logic [3:0]  cap_be   [0:3];
    logic [31:0] cap_wd   [0:3];
    int          cap_n    [0:3];
    int          n_en, resp_n, pulses;
    logic        ready1, got_err;
    logic [31:0] got_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issue one request and record every BRAM access until the response (bounded).
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        n_en = 0; resp_n = 0; ready1 = req_ready; got_err = 1'b0; got_rdata = 32'h0;
        for (int n = 1; n <= 24; n++) begin
            if (mem_en && n_en < 4) begin
                cap_addr[n_en] = mem_addr; cap_be[n_en] = mem_be;
                cap_wd[n_en] = mem_wdata; cap_n[n_en] = n;
                n_en++;
            end
            if (resp_valid) begin
                resp_n = n; got_rdata = resp_rdata; got_err = resp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst_mem_addr", {2'b0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b1;

        // LW aligned
        preload(8'h40, 32'hDEAD_BEEF);
        do_req(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        chk("lw_busy_ready", {31'b0, ready1}, 32'd0);
        chk("lw_n_en", n_en, 32'd1);
        chk("lw_addr", {2'b0, cap_addr[0]}, 32'h40);
        chk("lw_be", {28'b0, cap_be[0]}, 32'd0);
        chk("lw_lat", resp_n, 32'd4);
        chk("lw_rdata", got_rdata, 32'hDEAD_BEEF);
        chk("lw_err", {31'b0, got_err}, 32'd0);
        @(negedge clk);
        chk("lw_pulse_single", {31'b0, resp_valid}, 32'd0);

        // LB / LBU at offset 3
        preload(8'h40, 32'h80FF_0000);
        do_req(1'b0, 3'b000, 32'h0000_0103, 32'h0);
        chk("lb_n_en", n_en, 32'd1);
        chk("lb_lat", resp_n, 32'd4);
        chk("lb_rdata", got_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 3'b100, 32'h0000_0103, 32'h0);
        chk("lbu_rdata", got_rdata, 32'h0000_0080);

        // LH / LHU at offset 2 (fits in word)
        preload(8'h40, 32'h8001_7777);
        do_req(1'b0, 3'b001, 32'h0000_0102, 32'h0);
        chk("lh2_n_en", n_en, 32'd1);
        chk("lh2_rdata", got_rdata, 32'hFFFF_8001);
        do_req(1'b0, 3'b101, 32'h0000_0102, 32'h0);
        chk("lhu2_rdata", got_rdata, 32'h0000_8001);

        // SW split at 0x102
        preload(8'h40, 32'h0);
        preload(8'h41, 32'h0);
        do_req(1'b1, 3'b010, 32'h0000_0102, 32'h1122_3344);
        chk("sw_n_en", n_en, 32'd2);
        chk("sw_addr0", {2'b0, cap_addr[0]}, 32'h40);
        chk("sw_be0", {28'b0, cap_be[0]}, 32'hC);
        chk("sw_wd0", cap_wd[0], 32'h3344_0000);
        chk("sw_addr1", {2'b0, cap_addr[1]}, 32'h41);
        chk("sw_be1", {28'b0, cap_be[1]}, 32'h3);
        chk("sw_wd1", cap_wd[1], 32'h0000_1122);
        chk("sw_n1", cap_n[1], 32'd2);
        chk("sw_lat", resp_n, 32'd3);
        chk("sw_rdata", got_rdata, 32'h0);
        chk("sw_mem40", bram[8'h40], 32'h3344_0000);
        chk("sw_mem41", bram[8'h41], 32'h0000_1122);

        // SB aligned, upper wdata bits masked
        preload(8'h80, 32'h0);
        do_req(1'b1, 3'b000, 32'h0000_0201, 32'h1234_56EE);
        chk("sb_n_en", n_en, 32'd1);
        chk("sb_be", {28'b0, cap_be[0]}, 32'h2);
        chk("sb_wd", cap_wd[0], 32'h0000_EE00);
        chk("sb_lat", resp_n, 32'd2);
        chk("sb_mem", bram[8'h80], 32'h0000_EE00);

        // LH split at 0x103
        preload(8'h40, 32'hAB00_0000);
        preload(8'h41, 32'h0000_00CD);
        do_req(1'b0, 3'b001, 32'h0000_0103, 32'h0);
        chk("lhs_n_en", n_en, 32'd2);
        chk("lhs_addr1", {2'b0, cap_addr[1]}, 32'h41);
        chk("lhs_n1", cap_n[1], 32'd4);
        chk("lhs_lat", resp_n, 32'd7);
        chk("lhs_rdata", got_rdata, 32'hFFFF_CDAB);

        // LW split at 0x101
        preload(8'h40, 32'h4433_2211);
        preload(8'h41, 32'h8877_6655);
        do_req(1'b0, 3'b010, 32'h0000_0101, 32'h0);
        chk("lws_lat", resp_n, 32'd7);
        chk("lws_rdata", got_rdata, 32'h5544_3322);

        // Illegal funct3 values
        do_req(1'b0, 3'b110, 32'h0000_0100, 32'h0);
        chk("ill110_n_en", n_en, 32'd0);
        chk("ill110_err", {31'b0, got_err}, 32'd1);
        do_req(1'b1, 3'b100, 32'h0000_0100, 32'h0);
        chk("illsbu_err", {31'b0, got_err}, 32'd1);
        chk("illsbu_n_en", n_en, 32'd0);

        // funct3=011 held valid: back-to-back illegal accepts every two cycles
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 32'h100;
        @(negedge clk);
        chk("b2b_resp1", {31'b0, resp_valid}, 32'd1);
        chk("b2b_err1", {31'b0, resp_err}, 32'd1);
        chk("b2b_rdata1", resp_rdata, 32'h0);
        chk("b2b_men1", {31'b0, mem_en}, 32'd0);
        @(negedge clk);
        chk("b2b_gap", {31'b0, resp_valid}, 32'd0);
        chk("b2b_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        chk("b2b_resp2", {31'b0, resp_valid}, 32'd1);
        chk("b2b_err2", {31'b0, resp_err}, 32'd1);
        req_valid = 1'b0;
        @(negedge clk);

        // Reset while in WAIT0
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_ready", {31'b0, req_ready}, 32'd1);
        chk("mrst_resp", {31'b0, resp_valid}, 32'd0);
        rst = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        chk("mrst_no_resp", pulses, 32'd0);

        // Split store at top word wraps to word 0
        preload(8'hFF, 32'h0);
        preload(8'h00, 32'h0);
        do_req(1'b1, 3'b010, 32'hFFFF_FFFE, 32'hA1B2_C3D4);
        chk("wrap_addr0", {2'b0, cap_addr[0]}, 32'h3FFF_FFFF);
        chk("wrap_addr1", {2'b0, cap_addr[1]}, 32'h0);
        chk("wrap_wd0", cap_wd[0], 32'hC3D4_0000);
        chk("wrap_wd1", cap_wd[1], 32'h0000_A1B2);
        chk("wrap_mem0", bram[8'h00], 32'h0000_A1B2);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
